scalar_wb_arbiter: RTL and testbench

Shares the single write port of the scalar register file among several writeback requesters (ALU, load unit, vector-unit scalar result) using round-robin arbitration with valid/ready handshakes. It also keeps a pending-write scoreboard so decode can stall on read-after-write hazards against the register file's two read ports. It sits between the execution units and the scalar register file's write-enable, destination and write-data inputs. Register 7 is externally driven, so the block never writes it.

---
 rtl/scalar_wb_arbiter_if.sv | 41 ++++
 rtl/scalar_wb_arbiter.sv | 140 ++++++++++++++
 tb/tb_scalar_wb_arbiter.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/scalar_wb_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module     : scalar_wb_arbiter_if
// Description: Writeback request, reservation/hazard and register-file write
//              signals shared between the execution units, decode and the
//              scalar writeback arbiter.
// Revision   : 1.0 - initial release
// ============================================================================
interface scalar_wb_arbiter_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3,
    parameter int N_REQ  = 3
);
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ-1:0]        req_ready;
    logic [N_REQ*ADDR_W-1:0] req_dest;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic                    rsv_valid;
    logic [ADDR_W-1:0]       rsv_dest;
    logic [ADDR_W-1:0]       src1;
    logic [ADDR_W-1:0]       src2;
    logic                    hazard;
    logic                    rf_we;
    logic [ADDR_W-1:0]       rf_dest;
    logic [DATA_W-1:0]       rf_wd;
    logic [2**ADDR_W-1:0]    pending;
    logic [7:0]              drop_cnt;

    // Arbiter side
    modport slave (
        input  req_valid, req_dest, req_data, rsv_valid, rsv_dest, src1, src2,
        output req_ready, hazard, rf_we, rf_dest, rf_wd, pending, drop_cnt
    );

    // Requester / decode / register-file side
    modport master (
        output req_valid, req_dest, req_data, rsv_valid, rsv_dest, src1, src2,
        input  req_ready, hazard, rf_we, rf_dest, rf_wd, pending, drop_cnt
    );
endinterface
`default_nettype wire

// File: rtl/scalar_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module     : scalar_wb_arbiter
// Description: Round-robin arbiter for the scalar register-file write port
//              with a registered commit stage, a pending-write scoreboard for
//              decode RAW stalls and a drop counter for writes to the
//              externally driven top register.
// Revision   : 1.0 - initial release
// ============================================================================
module scalar_wb_arbiter #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3,
    parameter int N_REQ  = 3
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    scalar_wb_arbiter_if.slave   wb_bus
);
    localparam int                PTR_W      = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int                N_REG      = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] c_R_TOP    = {ADDR_W{1'b1}};
    localparam logic [PTR_W:0]    c_NREQ     = (PTR_W+1)'(N_REQ);
    localparam logic [PTR_W-1:0]  c_LAST     = PTR_W'(N_REQ-1);
    localparam logic [7:0]        c_DROP_MAX = 8'hFF;

    // Registered state
    logic [PTR_W-1:0]  ptr_q,   ptr_d;
    logic              we_q,    we_d;
    logic [ADDR_W-1:0] dest_q,  dest_d;
    logic [DATA_W-1:0] wd_q,    wd_d;
    logic [N_REG-1:0]  pend_q,  pend_d;
    logic [7:0]        drop_q,  drop_d;

    // Combinational arbitration results
    logic              w_gnt_vld;
    logic [PTR_W-1:0]  w_gnt_idx;
    logic [N_REQ-1:0]  w_ready;
    logic [ADDR_W-1:0] w_dest_arr [N_REQ];
    logic [DATA_W-1:0] w_data_arr [N_REQ];
    logic [ADDR_W-1:0] w_gnt_dest;
    logic [DATA_W-1:0] w_gnt_data;
    logic              w_drop;

    // Unpack the flat request buses into per-requester lanes
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
        assign w_dest_arr[gi] = wb_bus.req_dest[gi*ADDR_W +: ADDR_W];
        assign w_data_arr[gi] = wb_bus.req_data[gi*DATA_W +: DATA_W];
    end

    // Search for the first valid requester starting at the round-robin pointer
    always_comb begin
        logic [PTR_W:0] v_cand;
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        w_ready   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            v_cand = {1'b0, ptr_q} + (PTR_W+1)'(k);
            if (v_cand >= c_NREQ) begin
                v_cand = v_cand - c_NREQ;
            end
            if (!w_gnt_vld && wb_bus.req_valid[v_cand[PTR_W-1:0]]) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = v_cand[PTR_W-1:0];
            end
        end
        // No back-pressure: the winner is always accepted this cycle
        if (w_gnt_vld) begin
            w_ready[w_gnt_idx] = 1'b1;
        end
    end

    assign w_gnt_dest = w_dest_arr[w_gnt_idx];
    assign w_gnt_data = w_data_arr[w_gnt_idx];
    assign w_drop     = w_gnt_vld && (w_gnt_dest == c_R_TOP);

    // Next-state for pointer, commit stage, scoreboard and drop counter
    always_comb begin
        ptr_d  = ptr_q;
        we_d   = 1'b0;
        dest_d = dest_q;
        wd_d   = wd_q;
        drop_d = drop_q;
        pend_d = pend_q;

        if (w_gnt_vld) begin
            ptr_d = (w_gnt_idx == c_LAST) ? '0 : w_gnt_idx + 1'b1;
        end

        // The top register is driven externally: accept but never write it,
        // and leave the last real write on rf_dest/rf_wd
        if (w_gnt_vld && !w_drop) begin
            we_d   = 1'b1;
            dest_d = w_gnt_dest;
            wd_d   = w_gnt_data;
        end

        if (w_drop && (drop_q != c_DROP_MAX)) begin
            drop_d = drop_q + 8'd1;
        end

        // Clear first so a same-cycle reservation of the committing register wins
        if (we_q) begin
            pend_d[dest_q] = 1'b0;
        end
        if (wb_bus.rsv_valid && (wb_bus.rsv_dest != c_R_TOP)) begin
            pend_d[wb_bus.rsv_dest] = 1'b1;
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q  <= '0;
            we_q   <= 1'b0;
            dest_q <= '0;
            wd_q   <= '0;
            pend_q <= '0;
            drop_q <= '0;
        end else begin
            ptr_q  <= ptr_d;
            we_q   <= we_d;
            dest_q <= dest_d;
            wd_q   <= wd_d;
            pend_q <= pend_d;
            drop_q <= drop_d;
        end
    end

    // Output drive; the top register never raises a hazard
    assign wb_bus.req_ready = w_ready;
    assign wb_bus.hazard    = (pend_q[wb_bus.src1] && (wb_bus.src1 != c_R_TOP)) ||
                              (pend_q[wb_bus.src2] && (wb_bus.src2 != c_R_TOP));
    assign wb_bus.rf_we     = we_q;
    assign wb_bus.rf_dest   = dest_q;
    assign wb_bus.rf_wd     = wd_q;
    assign wb_bus.pending   = pend_q;
    assign wb_bus.drop_cnt  = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_scalar_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module     : tb_scalar_wb_arbiter
// Description: Directed and randomized self-checking bench for
//              scalar_wb_arbiter against a behavioural reference model.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_scalar_wb_arbiter;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 3;
    localparam int N_REQ  = 3;

    logic clk;
    logic rst_n;

    scalar_wb_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .N_REQ(N_REQ)) bus ();

    scalar_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .N_REQ(N_REQ)) u_dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .wb_bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model state
    int       m_ptr;
    bit [7:0] m_pend;
    int       m_drop;
    bit       m_we;
    int       m_dest;
    int       m_wd;

    // Values sampled by the last cycle() call
    logic [2:0] s_ready;
    logic       s_haz;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ptr  = 0;
        m_pend = '0;
        m_drop = 0;
        m_we   = 0;
        m_dest = 0;
        m_wd   = 0;
    endtask

    // One clock cycle: inputs already applied; checks combinational outputs
    // mid-cycle, advances the model, then checks registered outputs.
    task automatic cycle(output int g);
        int exp_ready;
        int exp_haz;
        int d;
        int s1;
        int s2;
        @(negedge clk);
        g = -1;
        for (int k = 0; k < N_REQ; k++) begin
            int idx;
            idx = (m_ptr + k) % N_REQ;
            if (g < 0 && bus.req_valid[idx]) g = idx;
        end
        exp_ready = (g >= 0) ? (1 << g) : 0;
        s1 = int'(bus.src1);
        s2 = int'(bus.src2);
        exp_haz = ((m_pend[s1] && s1 != 7) || (m_pend[s2] && s2 != 7)) ? 1 : 0;
        s_ready = bus.req_ready;
        s_haz   = bus.hazard;
        check_eq("req_ready", 32'(s_ready), 32'(exp_ready));
        check_eq("hazard", 32'(s_haz), 32'(exp_haz));

        if (m_we) m_pend[m_dest] = 1'b0;
        if (bus.rsv_valid && bus.rsv_dest != 3'd7) m_pend[bus.rsv_dest] = 1'b1;
        m_we = 0;
        if (g >= 0) begin
            d = int'(bus.req_dest[g*ADDR_W +: ADDR_W]);
            m_ptr = (g + 1) % N_REQ;
            if (d == 7) begin
                if (m_drop < 255) m_drop++;
            end else begin
                m_we   = 1;
                m_dest = d;
                m_wd   = int'(bus.req_data[g*DATA_W +: DATA_W]);
            end
        end

        @(posedge clk);
        #1;
        check_eq("rf_we", 32'(bus.rf_we), 32'(m_we));
        check_eq("rf_dest", 32'(bus.rf_dest), 32'(m_dest));
        check_eq("rf_wd", 32'(bus.rf_wd), 32'(m_wd));
        check_eq("pending", 32'(bus.pending), 32'(m_pend));
        check_eq("drop_cnt", 32'(bus.drop_cnt), 32'(m_drop));
    endtask

    task automatic set_req(input int i, input bit v, input int dest, input int data);
        bus.req_valid[i]                 = v;
        bus.req_dest[i*ADDR_W +: ADDR_W] = ADDR_W'(dest);
        bus.req_data[i*DATA_W +: DATA_W] = DATA_W'(data);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        int cnt [N_REQ];

        bus.req_valid = '0;
        bus.req_dest  = '0;
        bus.req_data  = '0;
        bus.rsv_valid = 1'b0;
        bus.rsv_dest  = '0;
        bus.src1      = '0;
        bus.src2      = '0;
        rst_n         = 1'b0;
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_rf_we", 32'(bus.rf_we), 0);
        check_eq("rst_pending", 32'(bus.pending), 0);
        check_eq("rst_drop", 32'(bus.drop_cnt), 0);
        check_eq("rst_hazard", 32'(bus.hazard), 0);
        rst_n = 1'b1;

        // Single write and read-after-write on r4
        bus.rsv_valid = 1'b1; bus.rsv_dest = 3'd4;
        cycle(g);
        bus.rsv_valid = 1'b0; bus.src1 = 3'd4;
        cycle(g);
        check_eq("raw_haz_c1", 32'(s_haz), 1);
        cycle(g);
        set_req(0, 1'b1, 4, 16'h1CA7);
        cycle(g);
        check_eq("raw_ready_c3", 32'(s_ready), 32'h1);
        check_eq("raw_we_c4", 32'(bus.rf_we), 1);
        check_eq("raw_dest_c4", 32'(bus.rf_dest), 4);
        check_eq("raw_wd_c4", 32'(bus.rf_wd), 32'h1CA7);
        set_req(0, 1'b0, 0, 0);
        cycle(g);
        check_eq("raw_haz_c4", 32'(s_haz), 1);
        check_eq("raw_pend4_c5", 32'(bus.pending[4]), 0);
        cycle(g);
        check_eq("raw_haz_c5", 32'(s_haz), 0);
        bus.src1 = 3'd0;

        // Bring the pointer to 0, then full contention for six cycles
        set_req(2, 1'b1, 1, 16'h0202);
        cycle(g);
        set_req(2, 1'b0, 0, 0);
        for (int i = 0; i < N_REQ; i++) begin
            set_req(i, 1'b1, i + 1, 16'h1000 + i);
            cnt[i] = 0;
        end
        for (int k = 0; k < 6; k++) begin
            cycle(g);
            check_eq("rr_onehot", 32'($countones(s_ready)), 1);
            check_eq("rr_order", 32'(s_ready), 32'(1 << (k % 3)));
            for (int i = 0; i < N_REQ; i++) begin
                if (s_ready[i]) begin
                    cnt[i]++;
                    set_req(i, 1'b1, i + 1, 16'h2000 + 16 * k + i);
                end
            end
        end
        for (int i = 0; i < N_REQ; i++) check_eq("rr_count", 32'(cnt[i]), 2);
        bus.req_valid = '0;
        cycle(g);

        // Writes to r7 are accepted and dropped; counter saturates
        set_req(1, 1'b1, 7, 16'hFFFF);
        cycle(g);
        check_eq("r7_ready", 32'(s_ready), 32'h2);
        check_eq("r7_we", 32'(bus.rf_we), 0);
        check_eq("r7_drop1", 32'(bus.drop_cnt), 1);
        for (int k = 1; k < 300; k++) cycle(g);
        check_eq("r7_sat", 32'(bus.drop_cnt), 255);
        set_req(1, 1'b0, 0, 0);

        // Same-cycle reserve and commit of r2: set wins
        bus.rsv_valid = 1'b1; bus.rsv_dest = 3'd2;
        cycle(g);
        bus.rsv_valid = 1'b0;
        set_req(0, 1'b1, 2, 16'h2222);
        cycle(g);
        set_req(0, 1'b0, 0, 0);
        check_eq("col_we", 32'(bus.rf_we), 1);
        bus.rsv_valid = 1'b1; bus.rsv_dest = 3'd2; bus.src2 = 3'd2;
        cycle(g);
        bus.rsv_valid = 1'b0;
        check_eq("col_pend2", 32'(bus.pending[2]), 1);
        cycle(g);
        check_eq("col_haz", 32'(s_haz), 1);

        // Pointer hold and wrap
        set_req(1, 1'b1, 3, 16'h0303);
        cycle(g);
        set_req(1, 1'b0, 0, 0);
        set_req(0, 1'b1, 5, 16'h0505);
        cycle(g);
        check_eq("ptr_gnt0", 32'(s_ready), 32'h1);
        set_req(0, 1'b0, 0, 0);
        cycle(g);
        set_req(0, 1'b1, 6, 16'h0606);
        set_req(2, 1'b1, 1, 16'h0101);
        cycle(g);
        check_eq("ptr_gnt2", 32'(s_ready), 32'h4);
        bus.req_valid = '0;
        cycle(g);

        // Reset mid-stream with a commit in flight and pending = 8'h14
        bus.rsv_valid = 1'b1; bus.rsv_dest = 3'd4;
        set_req(0, 1'b1, 5, 16'h5555);
        cycle(g);
        bus.rsv_valid = 1'b0;
        set_req(0, 1'b0, 0, 0);
        check_eq("mid_pend", 32'(bus.pending), 32'h14);
        check_eq("mid_we", 32'(bus.rf_we), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_we", 32'(bus.rf_we), 0);
        check_eq("mid_rst_dest", 32'(bus.rf_dest), 0);
        check_eq("mid_rst_wd", 32'(bus.rf_wd), 0);
        check_eq("mid_rst_pend", 32'(bus.pending), 0);
        check_eq("mid_rst_drop", 32'(bus.drop_cnt), 0);
        check_eq("mid_rst_haz", 32'(bus.hazard), 0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle(g);
        check_eq("post_rst_we", 32'(bus.rf_we), 0);

        // Randomized traffic against the model
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (!bus.req_valid[i] && $urandom_range(1, 0) == 1) begin
                    set_req(i, 1'b1, int'($urandom_range(7, 0)), int'($urandom_range(16'hFFFF, 0)));
                end
            end
            bus.rsv_valid = ($urandom_range(3, 0) == 0);
            bus.rsv_dest  = ADDR_W'($urandom_range(7, 0));
            bus.src1      = ADDR_W'($urandom_range(7, 0));
            bus.src2      = ADDR_W'($urandom_range(7, 0));
            cycle(g);
            if (g >= 0) bus.req_valid[g] = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
